dmem_port: RTL and testbench
============================

# dmem_port

Data-memory responder on the memory side of the EX/MEM pipeline register. Each cycle it samples the 2-bit memory-control field, the memory address and the store data that EX/MEM presents. It then runs a multi-cycle word access against an internal word array, stalling the pipeline with `stall_o` until the access finishes. Load data is returned registered, with a one-cycle `rvalid_o` strobe for the MEM/WB stage.

## Interface
- `DEPTH`, 1024: number of 32-bit words; power of two, at least 4.
- `LATENCY`, 2: wait cycles before an access commits; range 1..15.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `Mem_i`  in  2  memory control from EX/MEM.
  - Bit 1 is MemWrite and bit 0 is MemRead.
  - 2'b00 means no access.
  - 2'b11 is illegal and is treated as 2'b00.
- `Memaddr_i`  in  32  byte address from EX/MEM.
- `Memdata_i`  in  32  store data from EX/MEM.
- `stall_o`  out  1  hold request to the PC, IF/ID, ID/EX and EX/MEM registers.
- `rdata_o`  out  32  load data; holds its value until the next load completes.
- `rvalid_o`  out  1  one-cycle strobe: a load completed and `rdata_o` is new.
- `fault_o`  out  1  one-cycle strobe: misaligned request discarded. Present only when `DMEM_MISALIGN_TRAP_EN` is defined.

## Operation
- **FSM states:** IDLE, BUSY, DONE.
- **Valid request:** in IDLE, `Mem_i` is 2'b01 (load) or 2'b10 (store). Any other value causes no action and leaves `stall_o` low.
- **IDLE with a valid request:**
  - Latch the operation, word index, and store data.
  - Load the down-counter with `LATENCY-1`.
  - Go to BUSY.
- **BUSY:**
  - When the counter is non-zero, decrement it.
  - When the counter is 0, commit the access and go to DONE.
  - Commit for a store: write the latched data to the array.
  - Commit for a load: register the array word into `rdata_o`.
- **DONE:** `Mem_i` is ignored, because EX/MEM still shows the completed request. Go to IDLE.
- **Word index:** `Memaddr_i[log2(DEPTH)+1:2]`. Higher address bits are ignored, so addresses wrap modulo `DEPTH*4`.
- **Byte offset:** `Memaddr_i[1:0]` is ignored unless `DMEM_MISALIGN_TRAP_EN` is defined.
- **`stall_o`:** combinational; equal to (IDLE and valid request) or BUSY.
- **`rvalid_o`:** registered; high only in the DONE cycle that follows a load.
- **Stores never raise `rvalid_o`.**
- **Reset:** FSM goes to IDLE, and the counter, `rdata_o`, `rvalid_o` and `fault_o` clear to 0.
  - An in-flight store is dropped and does not commit.
  - Array contents are not cleared.
  - `stall_o` is 0 in the cycle after reset unless a valid request is present.
- **Read-after-write to the same word on back-to-back requests:** the load returns the newly stored value.

## Timing
- Request first visible in cycle T, with the FSM in IDLE:
  - `stall_o` is high in cycles T through T+LATENCY, which is LATENCY+1 stall cycles.
  - The access commits on the edge that ends cycle T+LATENCY.
  - Cycle T+LATENCY+1 is DONE: `stall_o`=0, and for a load `rvalid_o`=1 with `rdata_o` valid.
  - EX/MEM advances at the end of the DONE cycle.
- Earliest acceptance of the next request: cycle T+LATENCY+2.
- Throughput: one access per LATENCY+2 cycles.
- Requests with no access (`Mem_i` not 2'b01 or 2'b10) cost zero cycles.
- If `rst_i` is high in cycle T together with a request, reset wins: no stall is held and the request is not accepted.

## Configuration
- Macro: `DMEM_MISALIGN_TRAP_EN`.
- **Defined:**
  - A valid request in IDLE with `Memaddr_i[1:0]` not 2'b00 is discarded.
  - No stall, no array access, and `rdata_o` is unchanged.
  - `fault_o`=1 in cycle T+1, and the FSM stays in IDLE.
  - `fault_o` resets to 0.
- **Undefined:**
  - The `fault_o` port is absent.
  - The low two address bits are ignored, so every request accesses the containing aligned word.

## Test plan
- **Store then load, LATENCY=2:**
  - Store 0xDEADBEEF to address 0x10: `stall_o` is high for exactly 3 cycles, and `rvalid_o` stays 0.
  - Load 0x10: `rvalid_o` pulses in cycle T+3 with `rdata_o`=0xDEADBEEF.
- **Wrap-around, DEPTH=1024:** store 0x12345678 to 0x1000, then load 0x0; `rdata_o` is 0x12345678.
- **Idle and illegal codes:** hold `Mem_i`=2'b11 and then 2'b00 for 5 cycles each; `stall_o`, `rvalid_o` and `rdata_o` stay unchanged, and the array is unmodified.
- **Reset mid-store:** store 0xAAAA5555 to 0x20, assert `rst_i` in cycle T+1, then load 0x20. The load returns the prior contents (0 after a preloaded clear), and `stall_o` is 0 in the cycle after reset.
- **LATENCY=1, back-to-back loads:** loads to 0x4 and 0x8 give `rvalid_o` pulses 3 cycles apart with correct data each time.
- **Misalignment, macro defined:** load 0x13; `fault_o` pulses in T+1, `stall_o` stays 0, `rdata_o` is unchanged.
- **Misalignment, macro undefined:** load 0x13 returns the word at 0x10.

Source files
------------

// File: rtl/dmem_port_if.sv
// rtl/dmem_port_if.sv - EX/MEM to data-memory request/response bundle (fault line under DMEM_MISALIGN_TRAP_EN)
interface dmem_port_if;
    logic [1:0]  mem;
    logic [31:0] memaddr;
    logic [31:0] memdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rvalid;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic        fault;

    modport master (output mem, memaddr, memdata, input stall, rdata, rvalid, fault);
    modport slave  (input mem, memaddr, memdata, output stall, rdata, rvalid, fault);
`else
    modport master (output mem, memaddr, memdata, input stall, rdata, rvalid);
    modport slave  (input mem, memaddr, memdata, output stall, rdata, rvalid);
`endif
endinterface

// File: rtl/dmem_port.sv
// rtl/dmem_port.sv - multi-cycle data-memory responder with pipeline stall (optional DMEM_MISALIGN_TRAP_EN)
module dmem_port #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    dmem_port_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic          op_write;
    logic [AW-1:0] idx;
    logic [31:0]   wdata;
    logic [31:0]   rdata_q;
    logic          rvalid_q;
    logic [31:0]   ram [DEPTH];

    logic          valid_req;
    logic          aligned;
    logic          accept;
    logic          commit;
    logic [AW-1:0] req_idx;

    assign req_idx   = bus.memaddr[AW+1:2];
    assign valid_req = (state == S_IDLE) && ((bus.mem == 2'b01) || (bus.mem == 2'b10));
    assign commit    = (state == S_BUSY) && (cnt == 4'd0);

`ifdef DMEM_MISALIGN_TRAP_EN
    logic fault_q;
    logic unused_addr;
    assign aligned     = (bus.memaddr[1:0] == 2'b00);
    assign unused_addr = ^bus.memaddr[31:AW+2];
`else
    logic unused_addr;
    assign aligned     = 1'b1;
    assign unused_addr = ^{bus.memaddr[31:AW+2], bus.memaddr[1:0]};
`endif

    assign accept = valid_req && aligned;

    // Hold the pipeline while a request is being accepted or an access is in flight; reset overrides a new request
    always_comb begin
        bus.stall = (accept && !rst_i) || (state == S_BUSY);
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;

    // Control FSM: latch request, count down latency, commit load data, then one DONE cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            op_write <= 1'b0;
            idx      <= '0;
            wdata    <= 32'd0;
            rdata_q  <= 32'd0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_write <= bus.mem[1];
                        idx      <= req_idx;
                        wdata    <= bus.memdata;
                        cnt      <= 4'(LATENCY - 1);
                        state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (!op_write) begin
                            rdata_q  <= ram[idx];
                            rvalid_q <= 1'b1;
                        end
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // EX/MEM still shows the finished request here, so it must not be re-accepted
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Word array: not cleared by reset; a store caught by reset never commits
    always_ff @(posedge clk_i) begin
        if (!rst_i && commit && op_write) begin
            ram[idx] <= wdata;
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    // One-cycle strobe for a discarded misaligned request
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= valid_req && !aligned;
        end
    end

    assign bus.fault = fault_q;
`endif
endmodule

// File: tb/tb_dmem_port.sv
// tb/tb_dmem_port.sv - directed self-checking bench for dmem_port (LATENCY=2 and LATENCY=1 instances)
module tb_dmem_port;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    dmem_port_if bus2 ();
    dmem_port_if bus1 ();

    dmem_port #(.DEPTH(1024), .LATENCY(2)) dut2 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus2.slave)
    );

    dmem_port #(.DEPTH(1024), .LATENCY(1)) dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus1.slave)
    );

    // One full access on the LATENCY=2 instance; caller is positioned just after a rising edge
    task automatic access2(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                           output int stalls, output logic rv_during, output logic done_rv,
                           output logic [31:0] done_rd, output int done_cyc);
        logic finished;
        finished = 1'b0;
        stalls = 0; rv_during = 1'b0; done_rv = 1'b0; done_rd = 32'd0; done_cyc = 0;
        bus2.mem = op; bus2.memaddr = addr; bus2.memdata = data;
        for (int i = 0; i < 20 && !finished; i++) begin
            @(negedge clk);
            if (bus2.stall) begin
                stalls++;
                if (bus2.rvalid) rv_during = 1'b1;
                @(posedge clk); #1;
            end else begin
                finished = 1'b1;
                done_rv = bus2.rvalid; done_rd = bus2.rdata; done_cyc = cyc;
            end
        end
        if (!finished) begin
            tests++; failed++;
            $display("FAIL access2_timeout: stall still %0b, required 0 within 20 cycles", bus2.stall);
        end
        @(posedge clk); #1;
        bus2.mem = 2'b00;
    endtask

    task automatic access1(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                           output int stalls, output logic done_rv,
                           output logic [31:0] done_rd, output int done_cyc);
        logic finished;
        finished = 1'b0;
        stalls = 0; done_rv = 1'b0; done_rd = 32'd0; done_cyc = 0;
        bus1.mem = op; bus1.memaddr = addr; bus1.memdata = data;
        for (int i = 0; i < 20 && !finished; i++) begin
            @(negedge clk);
            if (bus1.stall) begin
                stalls++;
                @(posedge clk); #1;
            end else begin
                finished = 1'b1;
                done_rv = bus1.rvalid; done_rd = bus1.rdata; done_cyc = cyc;
            end
        end
        if (!finished) begin
            tests++; failed++;
            $display("FAIL access1_timeout: stall still %0b, required 0 within 20 cycles", bus1.stall);
        end
        @(posedge clk); #1;
        bus1.mem = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus2.mem = 2'b00; bus2.memaddr = 32'd0; bus2.memdata = 32'd0;
        bus1.mem = 2'b00; bus1.memaddr = 32'd0; bus1.memdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        bus2.mem = 2'b01; bus2.memaddr = 32'h10;
        @(negedge clk);
        tests++;
        if (bus2.stall !== 1'b0) begin failed++; $display("FAIL reset_wins_stall: got %0b, required 0", bus2.stall); end
        @(posedge clk); #1;
        rst = 1'b0;
        bus2.mem = 2'b00;
        @(negedge clk);
        tests++;
        if (bus2.stall !== 1'b0) begin failed++; $display("FAIL reset_stall: got %0b, required 0", bus2.stall); end
        tests++;
        if (bus2.rvalid !== 1'b0) begin failed++; $display("FAIL reset_rvalid: got %0b, required 0", bus2.rvalid); end
        tests++;
        if (bus2.rdata !== 32'd0) begin failed++; $display("FAIL reset_rdata: got %h, required 0", bus2.rdata); end
`ifdef DMEM_MISALIGN_TRAP_EN
        tests++;
        if (bus2.fault !== 1'b0) begin failed++; $display("FAIL reset_fault: got %0b, required 0", bus2.fault); end
`endif
        @(posedge clk); #1;
        @(negedge clk);
        tests++;
        if (bus2.stall !== 1'b0 || bus2.rvalid !== 1'b0) begin
            failed++; $display("FAIL reset_req_dropped: stall %0b rvalid %0b, required 0 0", bus2.stall, bus2.rvalid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        int st; logic rvd; logic rv; logic [31:0] rd; int dc; int t0;
        t0 = cyc;
        access2(2'b10, 32'h10, 32'hDEADBEEF, st, rvd, rv, rd, dc);
        tests++;
        if (st !== 3) begin failed++; $display("FAIL store_stall_cycles: got %0d, required 3", st); end
        tests++;
        if (rvd !== 1'b0 || rv !== 1'b0) begin failed++; $display("FAIL store_rvalid: got %0b/%0b, required 0/0", rvd, rv); end
        t0 = cyc;
        access2(2'b01, 32'h10, 32'h0, st, rvd, rv, rd, dc);
        tests++;
        if (st !== 3) begin failed++; $display("FAIL load_stall_cycles: got %0d, required 3", st); end
        tests++;
        if (rv !== 1'b1 || (dc - t0) !== 3) begin
            failed++; $display("FAIL load_rvalid_timing: rvalid %0b at T+%0d, required 1 at T+3", rv, dc - t0);
        end
        tests++;
        if (rd !== 32'hDEADBEEF) begin failed++; $display("FAIL load_rdata: got %h, required deadbeef", rd); end
        @(negedge clk);
        tests++;
        if (bus2.rvalid !== 1'b0 || bus2.rdata !== 32'hDEADBEEF) begin
            failed++; $display("FAIL load_after_done: rvalid %0b rdata %h, required 0 deadbeef", bus2.rvalid, bus2.rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        int st; logic rvd; logic rv; logic [31:0] rd; int dc;
        access2(2'b10, 32'h1000, 32'h12345678, st, rvd, rv, rd, dc);
        access2(2'b01, 32'h0, 32'h0, st, rvd, rv, rd, dc);
        tests++;
        if (rv !== 1'b1 || rd !== 32'h12345678) begin
            failed++; $display("FAIL wrap_load: rvalid %0b rdata %h, required 1 12345678", rv, rd);
        end
    endtask

    task automatic test_idle_illegal();
        int st; logic rvd; logic rv; logic [31:0] rd; int dc; int bad;
        logic [31:0] held;
        logic [1:0] codes [2];
        codes[0] = 2'b11; codes[1] = 2'b00;
        held = bus2.rdata;
        for (int c = 0; c < 2; c++) begin
            bad = 0;
            bus2.mem = codes[c]; bus2.memaddr = 32'h10; bus2.memdata = 32'h0BADF00D;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (bus2.stall !== 1'b0 || bus2.rvalid !== 1'b0 || bus2.rdata !== held) bad++;
                @(posedge clk); #1;
            end
            tests++;
            if (bad !== 0) begin
                failed++; $display("FAIL idle_code_%0b: %0d bad cycles (stall %0b rvalid %0b rdata %h), required 0", codes[c], bad, bus2.stall, bus2.rvalid, bus2.rdata);
            end
        end
        bus2.mem = 2'b00;
        access2(2'b01, 32'h10, 32'h0, st, rvd, rv, rd, dc);
        tests++;
        if (rd !== 32'hDEADBEEF) begin failed++; $display("FAIL illegal_no_write: got %h, required deadbeef", rd); end
    endtask

    task automatic test_reset_mid_store();
        int st; logic rvd; logic rv; logic [31:0] rd; int dc;
        access2(2'b10, 32'h20, 32'h0, st, rvd, rv, rd, dc);
        bus2.mem = 2'b10; bus2.memaddr = 32'h20; bus2.memdata = 32'hAAAA5555;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus2.mem = 2'b00;
        @(negedge clk);
        tests++;
        if (bus2.stall !== 1'b0) begin failed++; $display("FAIL rst_mid_stall: got %0b, required 0", bus2.stall); end
        tests++;
        if (bus2.rdata !== 32'd0 || bus2.rvalid !== 1'b0) begin
            failed++; $display("FAIL rst_mid_outputs: rdata %h rvalid %0b, required 0 0", bus2.rdata, bus2.rvalid);
        end
        @(posedge clk); #1;
        access2(2'b01, 32'h20, 32'h0, st, rvd, rv, rd, dc);
        tests++;
        if (rv !== 1'b1 || rd !== 32'd0 || st !== 3) begin
            failed++; $display("FAIL rst_mid_load: rvalid %0b rdata %h stalls %0d, required 1 0 3", rv, rd, st);
        end
    endtask

    task automatic test_back_to_back();
        int st; logic rv; logic [31:0] rd; int c1; int c2;
        access1(2'b10, 32'h4, 32'h11112222, st, rv, rd, c1);
        tests++;
        if (st !== 2) begin failed++; $display("FAIL lat1_store_stalls: got %0d, required 2", st); end
        access1(2'b10, 32'h8, 32'h33334444, st, rv, rd, c1);
        access1(2'b01, 32'h4, 32'h0, st, rv, rd, c1);
        tests++;
        if (rv !== 1'b1 || rd !== 32'h11112222) begin
            failed++; $display("FAIL lat1_load_a: rvalid %0b rdata %h, required 1 11112222", rv, rd);
        end
        access1(2'b01, 32'h8, 32'h0, st, rv, rd, c2);
        tests++;
        if (rv !== 1'b1 || rd !== 32'h33334444) begin
            failed++; $display("FAIL lat1_load_b: rvalid %0b rdata %h, required 1 33334444", rv, rd);
        end
        tests++;
        if ((c2 - c1) !== 3) begin failed++; $display("FAIL lat1_spacing: got %0d, required 3", c2 - c1); end
    endtask

    task automatic test_misalign();
`ifdef DMEM_MISALIGN_TRAP_EN
        logic [31:0] held;
        held = bus2.rdata;
        bus2.mem = 2'b01; bus2.memaddr = 32'h13;
        @(negedge clk);
        tests++;
        if (bus2.stall !== 1'b0) begin failed++; $display("FAIL misalign_stall: got %0b, required 0", bus2.stall); end
        @(posedge clk); #1;
        bus2.mem = 2'b00;
        @(negedge clk);
        tests++;
        if (bus2.fault !== 1'b1) begin failed++; $display("FAIL misalign_fault: got %0b, required 1", bus2.fault); end
        tests++;
        if (bus2.rdata !== held || bus2.rvalid !== 1'b0) begin
            failed++; $display("FAIL misalign_rdata: rdata %h rvalid %0b, required %h 0", bus2.rdata, bus2.rvalid, held);
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests++;
        if (bus2.fault !== 1'b0) begin failed++; $display("FAIL misalign_fault_clear: got %0b, required 0", bus2.fault); end
        @(posedge clk); #1;
`else
        int st; logic rvd; logic rv; logic [31:0] rd; int dc;
        access2(2'b01, 32'h13, 32'h0, st, rvd, rv, rd, dc);
        tests++;
        if (rv !== 1'b1 || rd !== 32'hDEADBEEF || st !== 3) begin
            failed++; $display("FAIL misalign_load: rvalid %0b rdata %h stalls %0d, required 1 deadbeef 3", rv, rd, st);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_wrap();
        test_idle_illegal();
        test_misalign();
        test_reset_mid_store();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
